// File: rtl/lfsr.sv
// ============================================================================
// Module   : lfsr
// Brief    : Maximal-length Fibonacci LFSR pseudo-random source (default 9 bit,
//            x^9+x^5+1). Optional seed loading under macro LFSR_SEED_LOAD_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lfsr #(
    parameter int               WIDTH = 9,
    parameter logic [WIDTH-1:0] TAPS  = 9'h110,
    parameter logic [WIDTH-1:0] SEED  = 9'h001
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
`ifdef LFSR_SEED_LOAD_EN
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_in,
`endif
    output logic [WIDTH-1:0] out
);

    localparam logic [WIDTH-1:0] c_ZERO = '0;

    logic [WIDTH-1:0] r_state;
    logic [WIDTH-1:0] w_step;
    logic [WIDTH-1:0] w_next;
    logic             w_fb;

    assign w_fb   = ^(r_state & TAPS);
    assign w_step = {r_state[WIDTH-2:0], w_fb};

    // An all-zero state is a fixed point of the XOR feedback, so any edge that
    // would otherwise keep it there restarts from SEED instead.
    always_comb begin
        w_next = r_state;
`ifdef LFSR_SEED_LOAD_EN
        if (seed_load) begin
            w_next = (seed_in == c_ZERO) ? SEED : seed_in;
        end else if (enable) begin
            w_next = (r_state == c_ZERO) ? SEED : w_step;
        end
`else
        if (enable) begin
            w_next = (r_state == c_ZERO) ? SEED : w_step;
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= SEED;
        end else begin
            r_state <= w_next;
        end
    end

    assign out = r_state;

endmodule

`default_nettype wire

// File: tb/tb_lfsr.sv
// ============================================================================
// Module   : tb_lfsr
// Brief    : Self-checking bench for lfsr against an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lfsr;

    localparam int c_WIDTH = 9;
    localparam int c_TAPS  = 'h110;
    localparam int c_SEED  = 'h001;
    localparam int c_MOD   = 512;

    logic                 clk;
    logic                 reset;
    logic                 enable;
    logic [c_WIDTH-1:0]   out;
`ifdef LFSR_SEED_LOAD_EN
    logic                 seed_load;
    logic [c_WIDTH-1:0]   seed_in;
`endif

    int checks;
    int errors;
    int model;

    lfsr dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
`ifdef LFSR_SEED_LOAD_EN
        .seed_load (seed_load),
        .seed_in   (seed_in),
`endif
        .out       (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Next value from the polynomial rule: double modulo 2^WIDTH, add parity
    // of the tapped bits; zero restarts from the seed.
    function automatic int model_next(input int s);
        int ones;
        ones = 0;
        if (s == 0) return c_SEED;
        for (int i = 0; i < c_WIDTH; i++) begin
            if (((s >> i) & 1) == 1 && ((c_TAPS >> i) & 1) == 1) ones++;
        end
        return ((s * 2) % c_MOD) + (ones % 2);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int expected);
        checks++;
        if (int'(out) !== expected) begin
            errors++;
            $display("FAIL %s: out=%03h expected=%03h at %0t", name, out, expected, $time);
        end
    endtask

    task automatic restart();
        reset = 1'b1;
        #1;
        tick();
        reset = 1'b0;
        model = c_SEED;
    endtask

    task automatic test_reset();
        reset  = 1'b0;
        enable = 1'b1;
        #1;
        reset = 1'b1;
        #1;
        check("reset_async_before_edge", c_SEED);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("reset_held", c_SEED);
        end
    endtask

    task automatic test_sequence();
        int exp_tab[9] = '{'h002, 'h004, 'h008, 'h010, 'h021, 'h042, 'h084, 'h108, 'h011};
        restart();
        enable = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tick();
            model = model_next(model);
            check("seq_table", exp_tab[i]);
            check("seq_model", model);
        end
    endtask

    task automatic test_hold();
        int n;
        enable = 1'b0;
        n = $urandom_range(5, 1);
        for (int i = 0; i < n; i++) begin
            tick();
            check("hold", model);
        end
        enable = 1'b1;
        tick();
        model = model_next(model);
        check("resume", model);
    endtask

    task automatic test_period();
        bit seen[c_MOD];
        restart();
        enable = 1'b1;
        for (int i = 0; i < c_MOD; i++) seen[i] = 1'b0;
        seen[c_SEED] = 1'b1;
        for (int i = 1; i <= 511; i++) begin
            tick();
            model = model_next(model);
            check("period_model", model);
            if (i < 511) begin
                checks++;
                if (out == '0 || seen[out]) begin
                    errors++;
                    $display("FAIL period_distinct: out=%03h repeated or zero at step %0d", out, i);
                end
                seen[out] = 1'b1;
            end
        end
        check("period_wrap", c_SEED);
    endtask

    task automatic test_random_enable();
        restart();
        for (int i = 0; i < 200; i++) begin
            enable = 1'($urandom_range(1, 0));
            tick();
            if (enable) model = model_next(model);
            check("random_enable", model);
        end
        enable = 1'b1;
    endtask

    task automatic test_async_reset();
        int k;
        restart();
        enable = 1'b1;
        k = $urandom_range(12, 4);
        for (int i = 0; i < k; i++) begin
            tick();
            model = model_next(model);
        end
        check("pre_async", model);
        #2;
        reset = 1'b1;
        #1;
        check("async_mid_run", c_SEED);
        tick();
        check("async_held_enable", c_SEED);
        reset = 1'b0;
        model = c_SEED;
        tick();
        model = model_next(model);
        check("after_async_release", model);
    endtask

`ifdef LFSR_SEED_LOAD_EN
    task automatic test_seed_load();
        int v;
        restart();
        enable    = 1'b1;
        seed_load = 1'b1;
        seed_in   = 9'h108;
        tick();
        check("load_108", 'h108);
        seed_load = 1'b0;
        tick();
        check("load_next_011", 'h011);
        seed_load = 1'b1;
        seed_in   = '0;
        tick();
        check("load_zero_guard", c_SEED);
        for (int i = 0; i < 20; i++) begin
            v         = $urandom_range(511, 0);
            seed_in   = 9'(v);
            seed_load = 1'b1;
            enable    = 1'($urandom_range(1, 0));
            tick();
            model = (v == 0) ? c_SEED : v;
            check("load_random", model);
            seed_load = 1'b0;
            enable    = 1'b1;
            tick();
            model = model_next(model);
            check("load_then_step", model);
        end
        seed_load = 1'b1;
        seed_in   = 9'h0AA;
        reset     = 1'b1;
        #1;
        tick();
        check("reset_over_load", c_SEED);
        reset     = 1'b0;
        seed_load = 1'b0;
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        model  = c_SEED;
        enable = 1'b0;
        reset  = 1'b0;
`ifdef LFSR_SEED_LOAD_EN
        seed_load = 1'b0;
        seed_in   = '0;
`endif
        test_reset();
        test_sequence();
        test_hold();
        test_period();
        test_random_enable();
        test_async_reset();
`ifdef LFSR_SEED_LOAD_EN
        test_seed_load();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
